// File: rtl/host_mem_avmm_rd_engine_pkg.sv
// Shared types and constants for the host-memory Avalon-MM read traffic engine.
package host_mem_avmm_rd_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } t_rd_state;

  localparam logic [1:0] AVMM_RESP_OKAY = 2'b00;

endpackage

// File: rtl/host_mem_rd_credit_cnt.sv
// Outstanding-line counter; has_room looks at next-cycle occupancy so the
// registered read request can be decided one cycle ahead.
module host_mem_rd_credit_cnt #(
  parameter int unsigned MAX_OUTSTANDING = 64,
  parameter int unsigned BURST_CNT_WIDTH = 7,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1) + 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [BURST_CNT_WIDTH-1:0] add,
  input  logic                       sub,
  input  logic [BURST_CNT_WIDTH-1:0] len,
  output logic                       has_room,
  output logic                       drained
);

  localparam int unsigned SUM_W = CNT_W + 1;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [SUM_W-1:0] room_sum;

  always_comb begin
    count_next = count + CNT_W'(add) - CNT_W'(sub);
    room_sum   = {1'b0, count_next} + SUM_W'(len);
    has_room   = (room_sum <= SUM_W'(MAX_OUTSTANDING));
    drained    = (count_next == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/host_mem_avmm_rd_engine.sv
// Issues a programmed number of fixed-length read bursts on a host-memory
// Avalon-MM port, limits lines in flight, and folds returned data into rd_xor.
module host_mem_avmm_rd_engine
  import host_mem_avmm_rd_engine_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 42,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned BURST_CNT_WIDTH = 7,
  parameter int unsigned MAX_OUTSTANDING = 64,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic [ADDR_WIDTH-1:0]                base_addr,
  input  logic [CNT_WIDTH-1:0]                 num_bursts,
  input  logic [BURST_CNT_WIDTH-1:0]           burst_len,
  output logic [ADDR_WIDTH-1:0]                avm_address,
  output logic [BURST_CNT_WIDTH-1:0]           avm_burstcount,
  output logic                                 avm_read,
  input  logic                                 avm_waitrequest,
  input  logic [DATA_WIDTH-1:0]                avm_readdata,
  input  logic                                 avm_readdatavalid,
  input  logic [1:0]                           avm_response,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error,
  output logic [CNT_WIDTH+BURST_CNT_WIDTH-1:0] lines_rcvd,
  output logic [CNT_WIDTH-1:0]                 cycles,
  output logic [63:0]                          rd_xor
);

  localparam int unsigned LINES_W = CNT_WIDTH + BURST_CNT_WIDTH;
  localparam logic [BURST_CNT_WIDTH-1:0] MAX_BURST =
    BURST_CNT_WIDTH'(2 ** (BURST_CNT_WIDTH - 1));

  t_rd_state                  state;
  t_rd_state                  next_state;
  logic                       read_next;
  logic [CNT_WIDTH-1:0]       bursts_left;
  logic [BURST_CNT_WIDTH-1:0] len_q;
  logic [BURST_CNT_WIDTH-1:0] credit_add;
  logic                       accept;
  logic                       beat;
  logic                       last_accept;
  logic                       has_room;
  logic                       drained;
  logic                       cfg_empty;
  logic                       cfg_bad;
  logic [63:0]                fold;

  assign accept      = avm_read & ~avm_waitrequest;
  assign beat        = avm_readdatavalid & (state != ST_IDLE);
  assign last_accept = accept && (bursts_left == CNT_WIDTH'(1));
  assign credit_add  = accept ? len_q : '0;
  assign cfg_empty   = (num_bursts == '0) || (burst_len == '0);
  assign cfg_bad     = (burst_len > MAX_BURST);

  host_mem_rd_credit_cnt #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .BURST_CNT_WIDTH (BURST_CNT_WIDTH)
  ) u_credit (
    .clk      (clk),
    .reset_n  (reset_n),
    .add      (credit_add),
    .sub      (beat),
    .len      (len_q),
    .has_room (has_room),
    .drained  (drained)
  );

  always_comb begin
    fold = '0;
    for (int unsigned i = 0; i < DATA_WIDTH / 64; i++) begin
      fold = fold ^ avm_readdata[i*64 +: 64];
    end
  end

  // A stalled request must stay up; otherwise re-request only if the next
  // cycle's occupancy leaves room for a whole burst.
  always_comb begin
    next_state = state;
    read_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !cfg_empty && !cfg_bad) begin
          next_state = ST_ISSUE;
          read_next  = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (last_accept) begin
          next_state = ST_DRAIN;
        end else if (avm_read && avm_waitrequest) begin
          read_next = 1'b1;
        end else begin
          read_next = has_room;
        end
      end
      ST_DRAIN: begin
        if (drained) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      avm_read <= 1'b0;
    end else begin
      state    <= next_state;
      avm_read <= read_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_address    <= '0;
      avm_burstcount <= '0;
      len_q          <= '0;
      bursts_left    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      lines_rcvd     <= '0;
      cycles         <= '0;
      rd_xor         <= '0;
    end else if (state == ST_IDLE && start) begin
      avm_address    <= base_addr;
      avm_burstcount <= burst_len;
      len_q          <= burst_len;
      bursts_left    <= num_bursts;
      busy           <= !(cfg_empty || cfg_bad);
      done           <= cfg_empty || cfg_bad;
      error          <= !cfg_empty && cfg_bad;
      lines_rcvd     <= '0;
      cycles         <= '0;
      rd_xor         <= '0;
    end else begin
      if (accept) begin
        avm_address <= avm_address + ADDR_WIDTH'(len_q);
        bursts_left <= bursts_left - CNT_WIDTH'(1);
      end
      if (beat) begin
        lines_rcvd <= lines_rcvd + LINES_W'(1);
        rd_xor     <= rd_xor ^ fold;
        error      <= error | (avm_response != AVMM_RESP_OKAY);
      end
      if (busy && cycles != '1) begin
        cycles <= cycles + CNT_WIDTH'(1);
      end
      if (state == ST_DRAIN && drained) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_host_mem_avmm_rd_engine.sv
// Scoreboarded bench: expected request addresses and returned beats are queued
// as stimulus is driven and popped as the engine issues/consumes them.
module tb_host_mem_avmm_rd_engine;

  localparam int unsigned AW  = 42;
  localparam int unsigned DW  = 512;
  localparam int unsigned BW  = 7;
  localparam int unsigned MO  = 64;
  localparam int unsigned CW  = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] num_bursts;
  logic [BW-1:0] burst_len;
  logic [AW-1:0] avm_address;
  logic [BW-1:0] avm_burstcount;
  logic          avm_read;
  logic          avm_waitrequest;
  logic [DW-1:0] avm_readdata;
  logic          avm_readdatavalid;
  logic [1:0]    avm_response;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW+BW-1:0] lines_rcvd;
  logic [CW-1:0] cycles;
  logic [63:0]   rd_xor;

  always #5 clk = ~clk;

  host_mem_avmm_rd_engine #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .BURST_CNT_WIDTH (BW),
    .MAX_OUTSTANDING (MO),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .base_addr         (base_addr),
    .num_bursts        (num_bursts),
    .burst_len         (burst_len),
    .avm_address       (avm_address),
    .avm_burstcount    (avm_burstcount),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_response      (avm_response),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .lines_rcvd        (lines_rcvd),
    .cycles            (cycles),
    .rd_xor            (rd_xor)
  );

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } beat_t;

  beat_t         beat_q[$];
  logic [AW-1:0] exp_addr_q[$];

  int unsigned errors = 0;
  int unsigned checks = 0;

  int unsigned cyc = 0;
  int unsigned done_rises = 0;
  logic        done_d = 1'b0;
  logic        prev_rd = 1'b0;
  logic        prev_wr = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [BW-1:0] prev_bc = '0;
  int unsigned hold_idx = 0;
  int unsigned hold_left = 0;
  int unsigned delay = 0;
  int unsigned err_line = 9999;
  int unsigned beat_idx = 0;
  bit          count_beats = 1'b0;
  int          inflight = 0;
  int unsigned accepts = 0;
  int unsigned spurious = 0;
  int unsigned cfg_len = 0;
  logic [63:0] exp_xor = '0;
  logic        exp_err = 1'b0;
  int unsigned last_beat_slot = 0;
  int unsigned first_acc = 0;
  int unsigned last_acc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Avalon slave model: decides waitrequest, scores requests, returns beats.
  initial begin
    logic          wr;
    logic [DW-1:0] line;
    logic [63:0]   word;
    logic [63:0]   f;
    beat_t         b;
    avm_waitrequest   = 1'b0;
    avm_readdata      = '0;
    avm_readdatavalid = 1'b0;
    avm_response      = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (done && !done_d) done_rises++;
      done_d = done;

      if (prev_rd && prev_wr) begin
        chk("stall_read_held", {63'd0, avm_read}, 64'd1);
        chk("stall_addr_stable", 64'(avm_address), 64'(prev_addr));
        chk("stall_bc_stable", 64'(avm_burstcount), 64'(prev_bc));
      end

      wr = 1'b0;
      if (avm_read && accepts == hold_idx && hold_left > 0) begin
        wr = 1'b1;
        hold_left--;
      end

      if (avm_read && !wr) begin
        if (exp_addr_q.size() == 0) begin
          spurious++;
        end else begin
          chk("req_addr", 64'(avm_address), 64'(exp_addr_q.pop_front()));
          chk("req_bc", 64'(avm_burstcount), 64'(cfg_len));
        end
        chk("credit_limit", {63'd0, (inflight + int'(avm_burstcount)) <= int'(MO)}, 64'd1);
        inflight += int'(avm_burstcount);
        if (accepts == 0) first_acc = cyc;
        last_acc = cyc;
        accepts++;
        for (int unsigned k = 0; k < avm_burstcount; k++) begin
          f = '0;
          for (int unsigned w = 0; w < DW / 64; w++) begin
            word = {$urandom, $urandom};
            line[w*64 +: 64] = word;
            f ^= word;
          end
          b.due  = cyc + 1 + delay;
          b.data = line;
          b.resp = 2'b00;
          beat_q.push_back(b);
          b.data = {DW{1'b0}};
          b.data[63:0] = f;
          beat_q[beat_q.size()-1].resp = 2'b00;
        end
      end

      avm_readdatavalid = 1'b0;
      avm_response      = 2'b00;
      if (beat_q.size() > 0 && beat_q[0].due <= cyc) begin
        b = beat_q.pop_front();
        if (beat_idx == err_line) b.resp = 2'b10;
        avm_readdata      = b.data;
        avm_response      = b.resp;
        avm_readdatavalid = 1'b1;
        inflight--;
        if (count_beats) begin
          f = '0;
          for (int unsigned w = 0; w < DW / 64; w++) f ^= b.data[w*64 +: 64];
          exp_xor ^= f;
          if (b.resp != 2'b00) exp_err = 1'b1;
          last_beat_slot = cyc;
        end
        beat_idx++;
      end

      avm_waitrequest = wr;
      prev_rd   = avm_read;
      prev_wr   = wr;
      prev_addr = avm_address;
      prev_bc   = avm_burstcount;
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_read"}, {63'd0, avm_read}, 64'd0);
    chk({tag, "_addr"}, 64'(avm_address), 64'd0);
    chk({tag, "_bc"}, 64'(avm_burstcount), 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_error"}, {63'd0, error}, 64'd0);
    chk({tag, "_lines"}, 64'(lines_rcvd), 64'd0);
    chk({tag, "_cycles"}, 64'(cycles), 64'd0);
    chk({tag, "_xor"}, rd_xor, 64'd0);
  endtask

  task automatic launch(input logic [AW-1:0] base, input int unsigned nb, input int unsigned len,
                        input int unsigned dly, input int unsigned hidx, input int unsigned hlen,
                        input int unsigned eline, output int unsigned start_slot);
    logic [AW-1:0] a;
    delay = dly; hold_idx = hidx; hold_left = hlen; err_line = eline;
    beat_idx = 0; inflight = 0; accepts = 0; spurious = 0; cfg_len = len;
    exp_xor = '0; exp_err = 1'b0; done_rises = 0; count_beats = 1'b1;
    a = base;
    for (int unsigned i = 0; i < nb && len != 0 && len <= 64; i++) begin
      exp_addr_q.push_back(a);
      a = a + AW'(len);
    end
    base_addr = base; num_bursts = nb; burst_len = BW'(len);
    start = 1'b1;
    start_slot = cyc;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic run_case(input string tag, input logic [AW-1:0] base, input int unsigned nb,
                          input int unsigned len, input int unsigned dly, input int unsigned hidx,
                          input int unsigned hlen, input int unsigned eline, input bit consec);
    int unsigned t0;
    int unsigned n;
    int unsigned done_slot;
    launch(base, nb, len, dly, hidx, hlen, eline, t0);
    chk({tag, "_busy_t1"}, {63'd0, busy}, 64'd1);
    chk({tag, "_read_t1"}, {63'd0, avm_read}, 64'd1);
    chk({tag, "_addr_t1"}, 64'(avm_address), 64'(base));
    chk({tag, "_done_clr"}, {63'd0, done}, 64'd0);
    n = 0;
    while (!done && n < 5000) begin
      @(posedge clk); #2;
      n++;
    end
    done_slot = cyc;
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_done_lat"}, 64'(done_slot), 64'(last_beat_slot + 1));
    chk({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
    chk({tag, "_lines"}, 64'(lines_rcvd), 64'(nb * len));
    chk({tag, "_error"}, {63'd0, error}, {63'd0, exp_err});
    chk({tag, "_xor"}, rd_xor, exp_xor);
    chk({tag, "_cycles"}, 64'(cycles), 64'(last_beat_slot - t0));
    chk({tag, "_reqs_left"}, 64'(exp_addr_q.size()), 64'd0);
    chk({tag, "_spurious"}, 64'(spurious), 64'd0);
    chk({tag, "_outstanding"}, 64'(dut.u_credit.count), 64'd0);
    repeat (3) begin @(posedge clk); #2; end
    chk({tag, "_done_once"}, 64'(done_rises), 64'd1);
    if (consec) chk({tag, "_b2b"}, 64'(last_acc - first_acc), 64'(nb - 1));
  endtask

  task automatic run_degen(input string tag, input int unsigned nb, input int unsigned len,
                           input logic exp_e);
    int unsigned t0;
    launch(42'h2000, nb, len, 0, 0, 0, 9999, t0);
    chk({tag, "_done_t1"}, {63'd0, done}, 64'd1);
    chk({tag, "_busy_t1"}, {63'd0, busy}, 64'd0);
    chk({tag, "_read_t1"}, {63'd0, avm_read}, 64'd0);
    chk({tag, "_error"}, {63'd0, error}, {63'd0, exp_e});
    chk({tag, "_lines"}, 64'(lines_rcvd), 64'd0);
    repeat (4) begin @(posedge clk); #2; end
    chk({tag, "_spurious"}, 64'(spurious), 64'd0);
    chk({tag, "_cycles"}, 64'(cycles), 64'd0);
  endtask

  initial begin
    int unsigned t0;
    int unsigned n;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; num_bursts = '0; burst_len = '0;
    repeat (3) @(posedge clk);
    #2;
    check_reset("por");
    reset_n = 1'b1;
    @(posedge clk); #2;

    run_case("basic",   42'h1000,        4, 4,  0, 0, 0, 9999, 1'b1);
    run_case("stall",   42'h5000,        4, 4,  2, 1, 5, 9999, 1'b0);
    run_case("credit",  42'h8000,        3, 64, 20, 0, 0, 9999, 1'b0);
    run_case("overlap", 42'hA000,        12, 2, 0, 0, 0, 9999, 1'b1);
    run_case("resp_err", 42'h3FFFFFFFFFA, 4, 4, 3, 0, 0, 7,    1'b0);

    // Abort while draining; late beats must be ignored.
    launch(42'hC000, 2, 8, 20, 0, 0, 9999, t0);
    n = 0;
    while ((exp_addr_q.size() != 0 || avm_read) && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    chk("rst_in_drain", {63'd0, busy}, 64'd1);
    reset_n = 1'b0;
    count_beats = 1'b0;
    #1;
    check_reset("rst_mid");
    chk("rst_mid_outstanding", 64'(dut.u_credit.count), 64'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    n = 0;
    while (beat_q.size() != 0 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    repeat (2) begin @(posedge clk); #2; end
    chk("rst_late_beats_drained", 64'(beat_q.size()), 64'd0);
    check_reset("rst_after");

    run_degen("len0",  4, 0,  1'b0);
    run_degen("len65", 4, 65, 1'b1);
    run_degen("nb0",   0, 4,  1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/host_mem_avmm_rd_engine.md
# host_mem_avmm_rd_engine

Read traffic engine that drives one group-1 host-memory Avalon-MM port inside the AFU, consuming the `host_mem_g1` ports built by the platform shim. Control inputs come from the AFU's CSR logic. On `start` the engine issues a programmed number of fixed-length line-address read bursts, limits outstanding lines with a credit counter, and reports completion, line count, cycle count, error and a 64-bit XOR fold of all returned data.

## Interface
- `ADDR_WIDTH`, 42: line-address width.
- `DATA_WIDTH`, 512: line width; multiple of 64.
- `BURST_CNT_WIDTH`, 7: Avalon burstcount width.
- `MAX_OUTSTANDING`, 64: maximum lines in flight; ≥ 2^(BURST_CNT_WIDTH-1).
- `CNT_WIDTH`, 32: width of `num_bursts` and `cycles`.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that launches a run.
- `base_addr` in ADDR_WIDTH: first line address.
- `num_bursts` in CNT_WIDTH: number of bursts to issue.
- `burst_len` in BURST_CNT_WIDTH: lines per burst.
- `avm_address` out ADDR_WIDTH: Avalon request address.
- `avm_burstcount` out BURST_CNT_WIDTH: Avalon request burstcount.
- `avm_read` out 1: Avalon read request.
- `avm_waitrequest` in 1: Avalon backpressure.
- `avm_readdata` in DATA_WIDTH: returned line data.
- `avm_readdatavalid` in 1: returned line valid.
- `avm_response` in 2: per-line response; nonzero means error.
- `busy` out 1: run in progress.
- `done` out 1: sticky; set at end of run, cleared by the next accepted `start`.
- `error` out 1: sticky; any nonzero response or illegal config during the run.
- `lines_rcvd` out CNT_WIDTH+BURST_CNT_WIDTH: count of returned lines.
- `cycles` out CNT_WIDTH: cycles from start to done; saturates.
- `rd_xor` out 64: XOR of every 64-bit slice of every returned line.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE + `start`:
  - Latch the config.
  - Clear `done`, `error`, `lines_rcvd`, `cycles`, `rd_xor`.
  - Set `busy`.
  - If `num_bursts`==0 or `burst_len`==0, go straight to done (no requests, `error`=0).
  - If `burst_len` > 2^(BURST_CNT_WIDTH-1), go straight to done with `error`=1 (no requests).
  - Otherwise enter ISSUE.
- ISSUE:
  - Assert `avm_read` only while `outstanding + burst_len ≤ MAX_OUTSTANDING`.
  - A burst is accepted when `avm_read`=1 and `avm_waitrequest`=0. On acceptance: `avm_address += burst_len` (wraps modulo 2^ADDR_WIDTH) and decrement the bursts-remaining counter.
  - After the last burst is accepted, go to DRAIN.
- DRAIN: when `outstanding`==0 and no beat arrives this cycle, go to IDLE, set `done`=1, clear `busy`.
- `outstanding` update: `outstanding += (accept ? burst_len : 0) − (avm_readdatavalid ? 1 : 0)`. A simultaneous accept and beat must net correctly.
- Beats while `busy`: increment `lines_rcvd`, fold `avm_readdata` into `rd_xor`, OR `(avm_response != 0)` into `error`.
- Beats in IDLE are ignored. `start` while `busy` is ignored.

## Timing
- Reset values: `avm_read`=0, `avm_address`=0, `avm_burstcount`=0, `busy`=0, `done`=0, `error`=0, `lines_rcvd`=0, `cycles`=0, `rd_xor`=0. FSM resets to IDLE with `outstanding`=0.
- All outputs are registered.
- `start` at cycle T: `busy`=1 and `avm_read`=1 at T+1 (credit permitting).
- While `avm_read`=1 and `avm_waitrequest`=1, `avm_address` and `avm_burstcount` hold stable. `avm_read` never drops without acceptance.
- Back-to-back bursts are issued every cycle when `waitrequest`=0 and credits are available.
- Last beat at cycle L: `done`=1 and `busy`=0 at L+1.
- `cycles` counts every cycle with `busy`=1.
- Degenerate or illegal config: `done` at T+1.
- Reset mid-run aborts immediately to reset values. Responses still in flight afterwards are ignored (engine is IDLE).

## Structure
- `host_mem_avmm_rd_engine_pkg` holds the state enum (`t_rd_state`) and the response-code constant `AVMM_RESP_OKAY`=2'b00.
- Sub-module `host_mem_rd_credit_cnt` holds the outstanding-line counter. Inputs: `add` (burst_len on accept), `sub` (one per beat). Output: `has_room(burst_len)`. Parameter: `MAX_OUTSTANDING`.

## Test plan
- base=0x1000, num_bursts=4, burst_len=4, no backpressure → addresses 0x1000/0x1004/0x1008/0x100C issued on consecutive cycles; `lines_rcvd`=16; `done`=1, `error`=0.
- `waitrequest` held high 5 cycles on burst 2 → address and burstcount stable for all 5 cycles; no duplicate issue; `lines_rcvd`=16.
- MAX_OUTSTANDING=64, burst_len=64, num_bursts=3, responses delayed 20 cycles → never more than 1 burst outstanding; `lines_rcvd`=192.
- Accept and readdatavalid in the same cycle, repeatedly → final `outstanding`=0; `done` asserts exactly once, one cycle after the last beat.
- `avm_response`=2'b10 on line 7 → `error`=1 at end; run still completes; `rd_xor` equals the model's fold.
- `burst_len`=0 → done at T+1, no `avm_read`. `burst_len`=65 (width 7) → done at T+1 with `error`=1. `reset_n` low mid-DRAIN → all outputs return to reset values.
